// File: rtl/vga_timing_pkg.sv
// Shared types for the VGA timing generator: the per-axis phase and the
// debug view of both phase FSMs.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    VISIBLE = 2'd0,
    FRONT   = 2'd1,
    SYNC    = 2'd2,
    BACK    = 2'd3
  } vga_phase_t;

  typedef struct packed {
    vga_phase_t h_phase;
    vga_phase_t v_phase;
    logic       frame_end;
  } vga_dbg_t;

  // Phase that owns position pos; zero-length regions simply never match.
  function automatic vga_phase_t phase_of(input int pos, input int vis,
                                          input int fp, input int sp);
    if (pos < vis) return VISIBLE;
    if (pos < vis + fp) return FRONT;
    if (pos < vis + fp + sp) return SYNC;
    return BACK;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus its region phase FSM.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VIS = 640,
  parameter int FP  = 16,
  parameter int SP  = 96,
  parameter int BP  = 48,
  localparam int WHOLE = VIS + FP + SP + BP,
  localparam int BITS  = $clog2(WHOLE)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            step,
  output logic [BITS-1:0] count,
  output vga_phase_t      phase,
  output logic            wrap
);

  localparam logic [BITS-1:0] LAST = BITS'(WHOLE - 1);

  logic [BITS-1:0] count_next;

  assign wrap = step && (count == LAST);

  always_comb begin
    count_next = count + 1'b1;
    if (count == LAST) count_next = '0;
  end

  // The phase is taken from the position being entered, so an empty region
  // is skipped within the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      phase <= VISIBLE;
    end else if (step) begin
      count <= count_next;
      phase <= phase_of(int'(count_next), VIS, FP, SP);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: pixel/line counters, sync and visible generation,
// and an optional inc-gated delay chain on the timing outputs.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_PULSE  = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_PULSE  = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter bit H_SYNC_POL    = 1'b0,
  parameter bit V_SYNC_POL    = 1'b0,
  parameter int PIPE_DELAY    = 0,
  localparam int H_WHOLE = H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
  localparam int V_WHOLE = V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
  localparam int X_BITS  = $clog2(H_WHOLE),
  localparam int Y_BITS  = $clog2(V_WHOLE)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              line_start,
  output logic              frame_start,
  output logic              visible,
  output logic              hsync,
  output logic              vsync,
  output vga_dbg_t          dbg
);

  vga_phase_t h_phase;
  vga_phase_t v_phase;
  logic       h_wrap;
  logic       v_wrap;
  logic [2:0] raw;

  vga_axis_counter #(
    .VIS(H_VISIBLE), .FP(H_FRONT_PORCH), .SP(H_SYNC_PULSE), .BP(H_BACK_PORCH)
  ) u_h (
    .clk(clk), .reset_n(reset_n), .step(inc),
    .count(x), .phase(h_phase), .wrap(h_wrap)
  );

  // The vertical axis advances on the same edge as the line wrap, so both
  // phases change together with no intermediate cycle.
  vga_axis_counter #(
    .VIS(V_VISIBLE), .FP(V_FRONT_PORCH), .SP(V_SYNC_PULSE), .BP(V_BACK_PORCH)
  ) u_v (
    .clk(clk), .reset_n(reset_n), .step(h_wrap),
    .count(y), .phase(v_phase), .wrap(v_wrap)
  );

  assign line_start  = inc && (x == '0);
  assign frame_start = inc && (x == '0) && (y == '0);

  assign raw[2] = (h_phase == VISIBLE) && (v_phase == VISIBLE);
  assign raw[1] = (h_phase == SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
  assign raw[0] = (v_phase == SYNC) ? V_SYNC_POL : ~V_SYNC_POL;

  assign dbg.h_phase   = h_phase;
  assign dbg.v_phase   = v_phase;
  assign dbg.frame_end = v_wrap;

  generate
    if (PIPE_DELAY == 0) begin : g_direct
      assign {visible, hsync, vsync} = raw;
    end else begin : g_delay
      localparam logic [2:0] IDLE_BITS = {1'b0, ~H_SYNC_POL, ~V_SYNC_POL};
      for (genvar i = 0; i < PIPE_DELAY; i++) begin : g_stage
        logic [2:0] d;
        logic [2:0] q;
        if (i == 0) begin : g_in
          assign d = raw;
        end else begin : g_link
          assign d = g_stage[i-1].q;
        end
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n)  q <= IDLE_BITS;
          else if (inc)  q <= d;
        end
      end
      assign {visible, hsync, vsync} = g_stage[PIPE_DELAY-1].q;
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing on small 8x6 / 7x6 rasters: reset, stall table,
// mid-frame reset, and a two-frame free run with polarity/delay variants.
module tb_vga_timing;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic inc = 1'b0;

  always #5 clk = ~clk;

  logic [2:0] xa, ya, xb, yb, xc, yc;
  logic ls_a, fs_a, vis_a, hs_a, vs_a;
  logic ls_b, fs_b, vis_b, hs_b, vs_b;
  logic ls_c, fs_c, vis_c, hs_c, vs_c;
  vga_dbg_t dbg_a, dbg_b, dbg_c;

  vga_timing #(
    .H_VISIBLE(4), .H_FRONT_PORCH(1), .H_SYNC_PULSE(2), .H_BACK_PORCH(1),
    .V_VISIBLE(3), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .inc(inc), .x(xa), .y(ya),
    .line_start(ls_a), .frame_start(fs_a), .visible(vis_a),
    .hsync(hs_a), .vsync(vs_a), .dbg(dbg_a)
  );

  vga_timing #(
    .H_VISIBLE(4), .H_FRONT_PORCH(1), .H_SYNC_PULSE(2), .H_BACK_PORCH(1),
    .V_VISIBLE(3), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1),
    .H_SYNC_POL(1'b1), .PIPE_DELAY(3)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .inc(inc), .x(xb), .y(yb),
    .line_start(ls_b), .frame_start(fs_b), .visible(vis_b),
    .hsync(hs_b), .vsync(vs_b), .dbg(dbg_b)
  );

  vga_timing #(
    .H_VISIBLE(4), .H_FRONT_PORCH(0), .H_SYNC_PULSE(2), .H_BACK_PORCH(1),
    .V_VISIBLE(3), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1)
  ) u_c (
    .clk(clk), .reset_n(reset_n), .inc(inc), .x(xc), .y(yc),
    .line_start(ls_c), .frame_start(fs_c), .visible(vis_c),
    .hsync(hs_c), .vsync(vs_c), .dbg(dbg_c)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chkp(input string name, input vga_phase_t act, input vga_phase_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%s required=%s", name, act.name(), exp.name());
    end
  endtask

  // Hand-derived region maps for the 4/1/2/1 and 4/0/2/1 lines and 3/1/1/1 frame.
  function automatic vga_phase_t a_hph(int px);
    if (px <= 3) return VISIBLE;
    if (px == 4) return FRONT;
    if (px <= 6) return SYNC;
    return BACK;
  endfunction

  function automatic vga_phase_t c_hph(int px);
    if (px <= 3) return VISIBLE;
    if (px <= 5) return SYNC;
    return BACK;
  endfunction

  function automatic vga_phase_t vph(int py);
    if (py <= 2) return VISIBLE;
    if (py == 3) return FRONT;
    if (py == 4) return SYNC;
    return BACK;
  endfunction

  // Undelayed {visible, hsync, vsync} of u_b (hsync active-high).
  function automatic logic [2:0] b_raw(int px, int py);
    logic v;
    logic h;
    logic s;
    v = (px < 4) && (py < 3);
    h = (px == 5) || (px == 6);
    s = (py != 4);
    return {v, h, s};
  endfunction

  typedef struct {
    logic inc;
    int   x;
    int   y;
    logic vis;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } vec_t;

  vec_t vecs[15];
  logic [2:0] exp_q[$];
  logic [2:0] exp_b;
  int ex, ey, cx, cy;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //                inc  x  y  vis hs vs ls fs
    vecs[0]  = '{1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 5, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 5, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 6, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 7, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state of all three variants.
    repeat (2) @(negedge clk);
    #1;
    chkn("rst_a_x", int'(xa), 0);
    chkn("rst_a_y", int'(ya), 0);
    chkp("rst_a_hph", dbg_a.h_phase, VISIBLE);
    chkp("rst_a_vph", dbg_a.v_phase, VISIBLE);
    chk1("rst_a_hsync", hs_a, 1'b1);
    chk1("rst_b_visible", vis_b, 1'b0);
    chk1("rst_b_hsync", hs_b, 1'b0);
    chk1("rst_b_vsync", vs_b, 1'b1);
    chkn("rst_c_x", int'(xc), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Stall/line table on u_a: values observed before each edge.
    for (int i = 0; i < 15; i++) begin
      inc = vecs[i].inc;
      #1;
      chkn($sformatf("tbl%0d_x", i), int'(xa), vecs[i].x);
      chkn($sformatf("tbl%0d_y", i), int'(ya), vecs[i].y);
      chk1($sformatf("tbl%0d_visible", i), vis_a, vecs[i].vis);
      chk1($sformatf("tbl%0d_hsync", i), hs_a, vecs[i].hs);
      chk1($sformatf("tbl%0d_vsync", i), vs_a, vecs[i].vs);
      chk1($sformatf("tbl%0d_line_start", i), ls_a, vecs[i].ls);
      chk1($sformatf("tbl%0d_frame_start", i), fs_a, vecs[i].fs);
      @(negedge clk);
    end

    // Advance from (1,1) to (5,2), then reset asynchronously mid-frame.
    inc = 1'b1;
    repeat (12) @(negedge clk);
    inc = 1'b0;
    #1;
    chkn("mid_pre_x", int'(xa), 5);
    chkn("mid_pre_y", int'(ya), 2);
    #1;
    reset_n = 1'b0;
    #1;
    chkn("mid_rst_x", int'(xa), 0);
    chkn("mid_rst_y", int'(ya), 0);
    chkp("mid_rst_hph", dbg_a.h_phase, VISIBLE);
    chkp("mid_rst_vph", dbg_a.v_phase, VISIBLE);
    chk1("mid_rst_b_visible", vis_b, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Two full frames of free run on every variant.
    exp_q = {3'b001, 3'b001, 3'b001};
    ex = 0; ey = 0; cx = 0; cy = 0;
    for (int k = 0; k < 96; k++) begin
      inc = 1'b1;
      #1;
      if (k == 0) chk1("first_inc_frame_start", fs_a, 1'b1);
      chkn("run_a_x", int'(xa), ex);
      chkn("run_a_y", int'(ya), ey);
      chk1("run_a_visible", vis_a, (ex < 4) && (ey < 3));
      chk1("run_a_hsync", hs_a, !((ex == 5) || (ex == 6)));
      chk1("run_a_vsync", vs_a, ey != 4);
      chk1("run_a_line_start", ls_a, ex == 0);
      chk1("run_a_frame_start", fs_a, (ex == 0) && (ey == 0));
      chk1("run_a_frame_end", dbg_a.frame_end, (ex == 7) && (ey == 5));
      chkp("run_a_hph", dbg_a.h_phase, a_hph(ex));
      chkp("run_a_vph", dbg_a.v_phase, vph(ey));
      exp_b = exp_q.pop_front();
      chk1("run_b_visible", vis_b, exp_b[2]);
      chk1("run_b_hsync", hs_b, exp_b[1]);
      chk1("run_b_vsync", vs_b, exp_b[0]);
      exp_q.push_back(b_raw(ex, ey));
      chkn("run_c_x", int'(xc), cx);
      chkp("run_c_hph", dbg_c.h_phase, c_hph(cx));
      chk1("run_c_hsync", hs_c, !((cx == 4) || (cx == 5)));
      chk1("run_c_visible", vis_c, (cx < 4) && (cy < 3));
      chk1("run_c_vsync", vs_c, cy != 4);
      @(negedge clk);
      if (ex == 7) begin
        ex = 0;
        ey = (ey == 5) ? 0 : ey + 1;
      end else begin
        ex++;
      end
      if (cx == 6) begin
        cx = 0;
        cy = (cy == 5) ? 0 : cy + 1;
      end else begin
        cx++;
      end
    end
    inc = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT_PORCH, default 16, pixels between the visible region and hsync.
REQ-003 SHALL have parameter H_SYNC_PULSE, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BACK_PORCH, default 48, pixels between hsync and the next line.
REQ-005 SHALL have parameters V_VISIBLE 480, V_FRONT_PORCH 10, V_SYNC_PULSE 2, V_BACK_PORCH 33, the same quantities in lines.
REQ-006 SHALL have parameters H_SYNC_POL and V_SYNC_POL, default 0, giving the asserted sync level (0 = active-low, 1 = active-high).
REQ-007 SHALL have parameter PIPE_DELAY, default 0, range 0..8, the pixel delay of visible/hsync/vsync relative to x/y.
REQ-008 SHALL derive localparams H_WHOLE (sum of the four H terms) and V_WHOLE (sum of the four V terms), with X_BITS = $clog2(H_WHOLE) and Y_BITS = $clog2(V_WHOLE).
REQ-009 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-010 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-011 SHALL have port inc, input, 1 bit: pixel advance enable.
REQ-012 SHALL have ports x [X_BITS] and y [Y_BITS], outputs: undelayed current pixel position.
REQ-013 SHALL have ports line_start and frame_start, outputs, 1 bit: position-0 markers aligned with x/y.
REQ-014 SHALL have ports visible, hsync and vsync, outputs, 1 bit: timing signals delayed by PIPE_DELAY pixels.

Function
REQ-015 SHALL hold all state unchanged in cycles with inc=0.
REQ-016 SHALL, on each inc=1 cycle, step x by 1, wrapping H_WHOLE-1 -> 0; y SHALL step by 1 only on that x wrap, wrapping V_WHOLE-1 -> 0.
REQ-017 SHALL track a per-axis phase FSM with states VISIBLE, FRONT, SYNC and BACK.
REQ-018 SHALL make each phase transition on the inc edge that moves the counter onto the phase boundary: VISIBLE->FRONT at H_VISIBLE, FRONT->SYNC at H_VISIBLE+H_FRONT_PORCH, SYNC->BACK at that value plus H_SYNC_PULSE, and BACK->VISIBLE on wrap to 0 (V analogous).
REQ-019 SHALL allow a phase length of 0 (porch only): the FSM skips that state in the same edge, and no cycle is spent in it.
REQ-020 SHALL produce the undelayed raw signals as: raw_visible = (h_phase==VISIBLE && v_phase==VISIBLE), raw_hsync = asserted iff h_phase==SYNC, raw_vsync = asserted iff v_phase==SYNC.
REQ-021 SHALL drive the asserted sync level as H_SYNC_POL / V_SYNC_POL, and the deasserted level as the inverse.
REQ-022 SHALL be combinational, from registered x/y/phases: line_start = inc && x==0; frame_start = inc && x==0 && y==0.
REQ-023 SHALL, when PIPE_DELAY=0, drive visible/hsync/vsync straight from the raw signals.
REQ-024 SHALL, when PIPE_DELAY=N>0, pass the raw signals through an N-stage register chain that shifts only when inc=1, so each output equals the raw value N inc-edges earlier.
REQ-025 SHALL, when vsync and hsync phases change on the same edge (line wrap into a new V phase), update both in that edge with no glitch cycle.

Reset
REQ-026 SHALL, while reset_n=0, immediately force: x=0, y=0, both phases VISIBLE, and every delay stage to visible=0 with syncs deasserted.
REQ-027 SHALL, when PIPE_DELAY>0, therefore show visible=0 and deasserted syncs for the first N inc edges after reset, whatever the raw values.
REQ-028 SHALL abandon any frame in progress if reset is asserted mid-frame; the first inc after release SHALL give frame_start=1.

Structure
REQ-029 SHALL take the phase enum type (vga_phase_t: VISIBLE, FRONT, SYNC, BACK) from the shared package vga_timing_pkg.
REQ-030 SHALL implement each axis with one sub-module, vga_axis_counter, instantiated twice; it is parametrised by the four region lengths and outputs count, phase and wrap.
REQ-031 SHALL implement the delay chain as a generate loop inside vga_timing.

Verification (all scenarios use H 4/1/2/1, H_WHOLE=8, and V 3/1/1/1, V_WHOLE=6, unless stated)
REQ-032 SHALL pass a free-run test: with inc=1 after reset, each line gives visible=1 for x=0..3 on y=0..2, hsync=0 for x=5..6, and vsync=0 for all of y=4; the sequence repeats every 48 cycles.
REQ-033 SHALL pass a stall test: toggling inc 1,0,0,1 holds x at 1 through the stalls, and there are no duplicate line_start pulses.
REQ-034 SHALL pass a polarity and delay test: with H_SYNC_POL=1 and PIPE_DELAY=3, hsync=1 exactly at the edges x=0..1 of the next line, and visible=0 for the first 3 incs after reset.
REQ-035 SHALL pass a zero-porch test: with H_FRONT_PORCH=0, h_phase goes VISIBLE->SYNC at x=4 and hsync is asserted for x=4..5.
REQ-036 SHALL pass a mid-frame reset test: reset_n pulsed low at x=5, y=2 gives x=y=0 asynchronously; the next inc gives frame_start=1.
REQ-037 SHALL pass a frame-wrap test: at x=7, y=5 with inc=1, the next cycle has x=0, y=0, and frame_start=1 if inc=1.
